// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM encoding,
// master indices and the default wait-state timeout.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int M_CPU           = 0;
  localparam int M_DMA           = 1;
  localparam int TIMEOUT_DEFAULT = 16;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; a tie goes to the master that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic last_q;
  logic last_d;

  // Winner selection and last-grant update
  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      winner_o = ~last_q;
    end else if (req_i[M_DMA]) begin
      winner_o = 1'(M_DMA);
    end else begin
      winner_o = 1'(M_CPU);
    end
    if (take_i && valid_o) begin
      last_d = winner_o;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; resets to DMA so the CPU wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'(M_DMA);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and burst sequencer for the byte-wide memory bus:
// round-robin grant, 1..4 beat bursts, wait states and timeout abort.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int dataWidth    = 8,
  parameter int addressWidth = 32,
  parameter int lenWidth     = 2,
  parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                m_req,
  input  logic [1:0]                m_we,
  input  logic [2*addressWidth-1:0] m_addr,
  input  logic [2*lenWidth-1:0]     m_len,
  input  logic [2*dataWidth-1:0]    m_wdata,
  output logic [1:0]                m_gnt,
  output logic [1:0]                m_ack,
  output logic [1:0]                m_done,
  output logic [1:0]                m_err,
  output logic [1:0]                m_rvalid,
  output logic [dataWidth-1:0]      m_rdata,
  output logic                      readmem,
  output logic                      writemem,
  output logic [addressWidth-1:0]   addressBus,
  output logic [dataWidth-1:0]      dataBusIn,
  input  logic [dataWidth-1:0]      dataBusOut,
  input  logic                      memDataReady
);

  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   we_q, we_d;
  logic [lenWidth-1:0]    len_q, len_d;
  logic [lenWidth-1:0]    beat_q, beat_d;
  logic [addressWidth-1:0] base_q, base_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [dataWidth-1:0]   rdata_q, rdata_d;

  logic arb_valid_s;
  logic arb_winner_s;
  logic busy_s;
  logic beat_ok_s;
  logic last_beat_s;
  logic timeout_s;

  rr_arbiter2 u_rr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .req_i   (m_req),
    .take_i  (state_q == IDLE),
    .valid_o (arb_valid_s),
    .winner_o(arb_winner_s)
  );

  assign busy_s      = (state_q == BUSY);
  assign beat_ok_s   = busy_s & memDataReady;
  assign last_beat_s = (beat_q == len_q);
  // The TIMEOUT-th consecutive not-ready cycle is the one that aborts
  assign timeout_s   = busy_s & ~memDataReady & (wait_q == WW'(TIMEOUT - 1));

  // State register and transfer context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      base_q   <= '0;
      wait_q   <= '0;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if ((beat_ok_s && last_beat_s) || timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer context: latch on grant, then count beats and wait states
  always_comb begin
    sel_d    = sel_q;
    we_d     = we_q;
    len_d    = len_q;
    base_d   = base_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    if (state_q == IDLE) begin
      beat_d = '0;
      wait_d = '0;
      if (arb_valid_s) begin
        sel_d  = arb_winner_s;
        we_d   = m_we[arb_winner_s];
        len_d  = m_len[arb_winner_s*lenWidth +: lenWidth];
        base_d = m_addr[arb_winner_s*addressWidth +: addressWidth];
      end else begin
        sel_d = sel_q;
      end
    end else if (beat_ok_s) begin
      beat_d = beat_q + lenWidth'(1);
      wait_d = '0;
      if (!we_q) begin
        rvalid_d = onehot2(sel_q);
        rdata_d  = dataBusOut;
      end else begin
        rvalid_d = 2'b00;
      end
    end else begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Bus and master-side outputs, all quiet outside BUSY
  always_comb begin
    m_gnt      = 2'b00;
    m_ack      = 2'b00;
    m_done     = 2'b00;
    m_err      = 2'b00;
    readmem    = 1'b0;
    writemem   = 1'b0;
    addressBus = '0;
    dataBusIn  = '0;
    if (busy_s) begin
      m_gnt      = onehot2(sel_q);
      readmem    = ~we_q;
      writemem   = we_q;
      addressBus = base_q + addressWidth'(beat_q);
      dataBusIn  = m_wdata[sel_q*dataWidth +: dataWidth];
      if (beat_ok_s) begin
        m_ack = onehot2(sel_q);
        if (last_beat_s) begin
          m_done = onehot2(sel_q);
        end else begin
          m_done = 2'b00;
        end
      end else if (timeout_s) begin
        m_err = onehot2(sel_q);
      end else begin
        m_err = 2'b00;
      end
    end else begin
      m_gnt = 2'b00;
    end
  end

  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level model predicts
// the winner, every beat's address/strobe/handshake and the read returns.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int LW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    m_req, m_we;
  logic [2*AW-1:0] m_addr;
  logic [2*LW-1:0] m_len;
  logic [2*DW-1:0] m_wdata;
  logic [1:0]    m_gnt, m_ack, m_done, m_err, m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          readmem, writemem;
  logic [AW-1:0] addressBus;
  logic [DW-1:0] dataBusIn, dataBusOut;
  logic          memDataReady;

  int n_tests = 0;
  int n_fail  = 0;

  int          last_w;
  logic [1:0]  exp_rv;
  logic [7:0]  exp_rd;
  logic [1:0]  p_we;
  logic [31:0] p_addr[2];
  int          p_len[2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_len(m_len), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack),
    .m_done(m_done), .m_err(m_err), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .readmem(readmem), .writemem(writemem), .addressBus(addressBus),
    .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .memDataReady(memDataReady)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_params();
    m_we   = p_we;
    m_addr = {p_addr[1], p_addr[0]};
    m_len  = {LW'(p_len[1]), LW'(p_len[0])};
  endtask

  // One cycle in which the bus must be idle; pending read data shows up here
  task automatic check_idle_cycle(input string tag);
    memDataReady = 1'($urandom);
    dataBusOut   = 8'($urandom);
    @(negedge clk);
    check_eq({tag, " idle gnt"}, m_gnt, 0);
    check_eq({tag, " idle strobes"}, {readmem, writemem}, 0);
    check_eq({tag, " idle addr"}, addressBus, 0);
    check_eq({tag, " idle ack/done/err"}, {m_ack, m_done, m_err}, 0);
    check_eq({tag, " idle rvalid"}, m_rvalid, exp_rv);
    if (exp_rv != 2'b00) check_eq({tag, " idle rdata"}, m_rdata, exp_rd);
    exp_rv = 2'b00;
    @(posedge clk); #1;
  endtask

  // Run the granted burst of master w; wait_mode 0 none, 1 random, 2 stuck, 3 ten per beat
  task automatic serve(input int w, input int wait_mode, input string tag);
    int   waits;
    int   wcnt;
    logic rdy;
    logic err_e;
    logic [7:0] wd;
    logic [7:0] rd_b;
    err_e = 1'b0;
    for (int b = 0; b <= p_len[w]; b++) begin
      case (wait_mode)
        0: waits = 0;
        3: waits = 10;
        default: waits = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(8, 14);
      endcase
      wd = 8'($urandom);
      m_wdata[w*DW +: DW] = wd;
      if ($urandom_range(0, 3) == 0) begin
        m_req[w] = 1'($urandom);
        m_addr[w*AW +: AW] = $urandom;
        m_we[w] = ~p_we[w];
        m_len[w*LW +: LW] = LW'($urandom);
      end
      wcnt = 0;
      forever begin
        rdy = (wait_mode == 2) ? 1'b0 : (wcnt >= waits);
        rd_b = 8'($urandom);
        memDataReady = rdy;
        dataBusOut = rd_b;
        @(negedge clk);
        err_e = !rdy && (wcnt == TO - 1);
        check_eq({tag, " gnt"}, m_gnt, 32'd1 << w);
        check_eq({tag, " readmem"}, readmem, !p_we[w]);
        check_eq({tag, " writemem"}, writemem, p_we[w]);
        check_eq({tag, " addr"}, addressBus, p_addr[w] + 32'(b));
        check_eq({tag, " wdata"}, dataBusIn, wd);
        check_eq({tag, " ack"}, m_ack, rdy ? (32'd1 << w) : 32'd0);
        check_eq({tag, " done"}, m_done, (rdy && b == p_len[w]) ? (32'd1 << w) : 32'd0);
        check_eq({tag, " err"}, m_err, err_e ? (32'd1 << w) : 32'd0);
        check_eq({tag, " rvalid"}, m_rvalid, exp_rv);
        if (exp_rv != 2'b00) check_eq({tag, " rdata"}, m_rdata, exp_rd);
        exp_rv = (rdy && !p_we[w]) ? 2'(32'd1 << w) : 2'b00;
        exp_rd = rd_b;
        @(posedge clk); #1;
        if (rdy || err_e) break;
        wcnt++;
      end
      if (err_e) break;
    end
  endtask

  // Raise the requests in mask and serve every requester in round-robin order
  task automatic scenario(input logic [1:0] mask, input int wait_mode, input string tag);
    logic [1:0] pending;
    int w;
    pending = mask;
    drive_params();
    m_req = pending;
    while (pending != 2'b00) begin
      w = (pending == 2'b11) ? 1 - last_w : (pending[1] ? 1 : 0);
      check_idle_cycle(tag);
      last_w = w;
      pending[w] = 1'b0;
      serve(w, wait_mode, tag);
      m_req = pending;
    end
    check_idle_cycle(tag);
  endtask

  task automatic randomize_params();
    for (int i = 0; i < 2; i++) begin
      p_we[i]   = 1'($urandom);
      p_addr[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      p_len[i]  = $urandom_range(0, 3);
    end
  endtask

  initial begin
    rst = 1'b0;
    m_req = 2'b00; m_we = 2'b00; m_addr = '0; m_len = '0; m_wdata = '0;
    dataBusOut = 8'h00; memDataReady = 1'b0;
    exp_rv = 2'b00; exp_rd = 8'h00;
    #2;
    check_eq("reset outs", {m_gnt, m_ack, m_done, m_err, m_rvalid, readmem, writemem}, 0);
    check_eq("reset addr/data", {addressBus[15:0], dataBusIn, m_rdata}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    last_w = 1;

    p_we = 2'b00; p_addr[0] = 32'h0010_0004; p_addr[1] = 32'h0; p_len[0] = 0; p_len[1] = 0;
    scenario(2'b01, 0, "single_read");
    p_addr[1] = 32'h0000_0100;
    scenario(2'b11, 0, "tie1");
    scenario(2'b11, 0, "tie2");
    p_we = 2'b10; p_addr[1] = 32'h0100_0000; p_len[1] = 3;
    scenario(2'b10, 0, "write_burst");
    p_we = 2'b00; p_addr[0] = 32'h0000_2000; p_len[0] = 1;
    scenario(2'b01, 3, "wait_clear");
    scenario(2'b01, 1, "wait_rand");
    scenario(2'b01, 2, "timeout");
    p_addr[0] = 32'hFFFF_FFFF; p_len[0] = 1;
    scenario(2'b01, 0, "wrap");

    // Reset during beat 2 of a 4-beat read
    p_we = 2'b00; p_addr[0] = 32'h2000_0000; p_len[0] = 3;
    drive_params();
    m_req = 2'b01;
    check_idle_cycle("rst_pre");
    memDataReady = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check_eq("rst_pre ack", m_ack, 2'b01);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check_eq("rst_mid outs", {m_gnt, m_ack, m_done, m_err, m_rvalid, readmem, writemem}, 0);
    check_eq("rst_mid addr", addressBus, 0);
    check_eq("rst_mid data", {dataBusIn, m_rdata}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_req = 2'b00;
    last_w = 1;
    exp_rv = 2'b00;
    p_len[0] = 0; p_len[1] = 0;
    scenario(2'b11, 0, "post_rst_tie");

    for (int n = 0; n < 80; n++) begin
      randomize_params();
      scenario(2'($urandom_range(1, 3)), ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
